hc595_shift_engine: RTL and testbench

- Self-timed serial driver for a chain of 74HC595 shift registers (7-segment display path).
- Divides the system clock to a periodic refresh tick and turns each tick into a one-cycle enable pulse.
- On each pulse, captures an N-bit word and shifts it out MSB-first on SER/SRCLK, then pulses RCLK to latch it.
- Sits between the display-data logic and the board pins.

---
 rtl/hc595_shift_engine_pkg.sv | 28 ++
 rtl/hc595_shift_engine_if.sv | 26 ++
 rtl/hc595_shift_engine_tick_gen.sv | 33 +++
 rtl/hc595_shift_engine.sv | 112 +++++++++++
 tb/tb_hc595_shift_engine.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/hc595_shift_engine_pkg.sv
// Shared types, default timing constants and width helpers for the 74HC595 serial driver.
package hc595_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } state_t;

    localparam int unsigned DEF_INPUT_CLK_FREQ = 100_000_000;
    localparam int unsigned DEF_TICK_FREQ      = 1000;

    function automatic int unsigned tick_period(int unsigned clk_freq, int unsigned tick_freq);
        return clk_freq / tick_freq;
    endfunction

    localparam int unsigned PERIOD = tick_period(DEF_INPUT_CLK_FREQ, DEF_TICK_FREQ);

    function automatic int unsigned bit_cnt_width(int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned phase_width(int unsigned half);
        return $clog2(half + 1);
    endfunction

endpackage

// File: rtl/hc595_shift_engine_if.sv
// Data word in, 595 pin bundle out; master is the driver side, slave the consumer/observer side.
interface hc595_shift_engine_if #(
    parameter int unsigned N = 32
);
    logic [N-1:0] data_in;
    logic         RDY;
    logic         SRCLK;
    logic         RCLK;
    logic         SER;

    modport master (
        input  data_in,
        output RDY,
        output SRCLK,
        output RCLK,
        output SER
    );

    modport slave (
        output data_in,
        input  RDY,
        input  SRCLK,
        input  RCLK,
        input  SER
    );
endinterface

// File: rtl/hc595_shift_engine_tick_gen.sv
// Free-running refresh divider producing a one-cycle enable pulse every PERIOD clocks.
module hc595_tick_gen
    import hc595_pkg::*;
#(
    parameter int unsigned INPUT_CLK_FREQ = DEF_INPUT_CLK_FREQ,
    parameter int unsigned TICK_FREQ      = DEF_TICK_FREQ
) (
    input  logic clk,
    input  logic rst_n,
    output logic en_pulse
);

    localparam int unsigned P  = tick_period(INPUT_CLK_FREQ, TICK_FREQ);
    localparam int unsigned CW = $clog2(P);

    logic [CW-1:0] cnt;

    // en_pulse is registered one count early so it is high exactly while cnt == P-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            en_pulse <= 1'b0;
        end else begin
            if (cnt == CW'(P - 1)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            en_pulse <= (cnt == CW'(P - 2));
        end
    end

endmodule

// File: rtl/hc595_shift_engine.sv
// Frame FSM and shift register: on each refresh pulse shifts an N-bit word MSB-first into a 595 chain, then latches it.
module hc595_shift_engine
    import hc595_pkg::*;
#(
    parameter int unsigned INPUT_CLK_FREQ = DEF_INPUT_CLK_FREQ,
    parameter int unsigned TICK_FREQ      = DEF_TICK_FREQ,
    parameter int unsigned N              = 32,
    parameter int unsigned SRCLK_HALF     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hc595_shift_engine_if.master  bus
);

    localparam int unsigned BCW = bit_cnt_width(N);
    localparam int unsigned PW  = phase_width(SRCLK_HALF);

    state_t          state;
    state_t          state_next;
    logic            en_pulse;
    logic [N-2:0]    shreg;
    logic [BCW-1:0]  bit_cnt;
    logic [PW-1:0]   phase;
    logic            phase_done;
    logic            last_bit;

    logic            rdy_q,   rdy_d;
    logic            srclk_q, srclk_d;
    logic            rclk_q,  rclk_d;
    logic            ser_q,   ser_d;

    hc595_tick_gen #(
        .INPUT_CLK_FREQ (INPUT_CLK_FREQ),
        .TICK_FREQ      (TICK_FREQ)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_pulse (en_pulse)
    );

    assign phase_done = (phase == PW'(SRCLK_HALF - 1));
    assign last_bit   = (bit_cnt == BCW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rdy_q   <= 1'b1;
            srclk_q <= 1'b0;
            rclk_q  <= 1'b0;
            ser_q   <= 1'b0;
        end else begin
            state   <= state_next;
            rdy_q   <= rdy_d;
            srclk_q <= srclk_d;
            rclk_q  <= rclk_d;
            ser_q   <= ser_d;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:     if (en_pulse)   state_next = SHIFT_LO;
            SHIFT_LO: if (phase_done) state_next = SHIFT_HI;
            SHIFT_HI: if (phase_done) state_next = last_bit ? LATCH : SHIFT_LO;
            LATCH:    if (phase_done) state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // Next values of the registered pins; SER only moves at frame start and on SRCLK falls.
    always_comb begin
        rdy_d   = (state_next == IDLE);
        srclk_d = (state_next == SHIFT_HI);
        rclk_d  = (state_next == LATCH);
        ser_d   = ser_q;
        if (state == IDLE && en_pulse) begin
            ser_d = bus.data_in[N-1];
        end else if (state == SHIFT_HI && phase_done) begin
            ser_d = last_bit ? 1'b0 : shreg[N-2];
        end
    end

    // The MSB goes straight to SER at load, so shreg only holds the N-1 bits still to be sent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
            phase   <= '0;
        end else begin
            if (state == IDLE || phase_done) begin
                phase <= '0;
            end else begin
                phase <= phase + 1'b1;
            end

            if (state == IDLE && en_pulse) begin
                shreg   <= bus.data_in[N-2:0];
                bit_cnt <= '0;
            end else if (state == SHIFT_HI && phase_done && !last_bit) begin
                shreg   <= {shreg[N-3:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    assign bus.RDY   = rdy_q;
    assign bus.SRCLK = srclk_q;
    assign bus.RCLK  = rclk_q;
    assign bus.SER   = ser_q;

endmodule

// File: tb/tb_hc595_shift_engine.sv
// Randomized bench comparing every output cycle against a timing-formula model of the 595 frame.
module tb_hc595_shift_engine;

    localparam int unsigned P   = 100;
    localparam int unsigned H   = 2;
    localparam int unsigned NB  = 32;
    localparam int          FL  = 2 * H * NB + H;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    hc595_shift_engine_if #(.N(NB)) bus ();

    hc595_shift_engine #(
        .INPUT_CLK_FREQ (100),
        .TICK_FREQ      (1),
        .N              (NB),
        .SRCLK_HALF     (H)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int          cyc;
    logic [31:0] dh [0:4095];
    int          cur_t;
    logic [31:0] cur_word;
    int          frames_exp;
    int          frames_seen;
    logic [31:0] seen_words [0:63];
    logic [31:0] acc;
    int          rises;
    logic        prev_srclk;
    logic        prev_rclk;
    bit          rand_data;

    logic [3:0] vec;
    assign vec = {bus.RDY, bus.SRCLK, bus.RCLK, bus.SER};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [3:0] model_vec(input int c);
        int o;
        logic rdy, sck, rck, ser;
        o = c - cur_t;
        if (o < 0 || o >= FL) return 4'b1000;
        rdy = 1'b0;
        sck = (o >= int'(H)) && (o < int'(2 * H * NB)) && (((o - int'(H)) % int'(2 * H)) < int'(H));
        rck = (o >= int'(2 * H * NB));
        ser = (o < int'(2 * H * NB)) ? cur_word[int'(NB) - 1 - o / int'(2 * H)] : 1'b0;
        return {rdy, sck, rck, ser};
    endfunction

    task automatic model_reset();
        cyc        = 0;
        cur_t      = -100000;
        acc        = '0;
        rises      = 0;
        prev_srclk = 1'b0;
        prev_rclk  = 1'b0;
    endtask

    task automatic run_cycle();
        @(posedge clk);
        #1;
        if (rst_n) begin
            cyc++;
            // A tick is taken only if the previous frame had already returned to idle.
            if (cyc % int'(P) == 0 && cyc > cur_t + FL) begin
                cur_t    = cyc;
                cur_word = dh[cyc];
            end
            if (cyc - cur_t == int'(2 * H * NB)) frames_exp++;
            check("pins", 32'(vec), 32'(model_vec(cyc)));
            if (bus.SRCLK && !prev_srclk) begin
                acc = {acc[30:0], bus.SER};
                rises++;
            end
            if (bus.RCLK && !prev_rclk) begin
                check("frame_word", acc, cur_word);
                check("srclk_rises", 32'(rises), 32'(NB));
                if (frames_seen < 64) seen_words[frames_seen] = acc;
                frames_seen++;
                acc   = '0;
                rises = 0;
            end
            prev_srclk = bus.SRCLK;
            prev_rclk  = bus.RCLK;
        end else begin
            check("reset_pins", 32'(vec), 32'h8);
        end
        if (rand_data && ($urandom_range(3) == 0)) bus.data_in = $urandom;
        if (cyc + 1 < 4096) dh[cyc + 1] = bus.data_in;
    endtask

    initial begin
        int guard;
        frames_exp  = 0;
        frames_seen = 0;
        rand_data   = 1'b0;
        cur_word    = '0;
        model_reset();
        bus.data_in = 32'hDEAFBEEF;
        for (int i = 0; i < 4096; i++) dh[i] = 32'hDEAFBEEF;

        for (int i = 0; i < 3; i++) run_cycle();
        rst_n = 1'b1;

        // First frame DEAFBEEF; data changed mid-frame must only show in the next one.
        while (cyc < 850) begin
            if (cyc == 140) bus.data_in = 32'h12345678;
            if (cyc == 140) dh[cyc + 1] = bus.data_in;
            if (cyc == 320) rand_data = 1'b1;
            run_cycle();
        end
        check("first_word", seen_words[0], 32'hDEAFBEEF);
        check("second_word", seen_words[1], 32'h12345678);
        check("frames_phase1", 32'(frames_seen), 32'(frames_exp));

        // Abort a frame after its 10th SRCLK rise.
        guard = 0;
        while (rises != 10 && guard < 400) begin
            run_cycle();
            guard++;
        end
        check("wait_10_rises", 32'(rises), 32'd10);
        rst_n = 1'b0;
        #1;
        check("async_reset", 32'(vec), 32'h8);
        model_reset();
        for (int i = 0; i < 3; i++) run_cycle();
        rst_n = 1'b1;

        while (cyc < 450) run_cycle();
        check("frames_total", 32'(frames_seen), 32'(frames_exp));
        check("frames_min", 32'(frames_seen >= 6), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
